// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the multi-channel edge-to-pulse generator.
// Holds the channel state encoding, edge-select codes and the edge decision.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } state_e;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    function automatic logic edge_detect(input logic s, input logic prev, input logic [1:0] mode);
        logic hit;
        hit = 1'b0;
        case (mode)
            MODE_RISE: hit = s & ~prev;
            MODE_FALL: hit = ~s & prev;
            MODE_BOTH: hit = s ^ prev;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pulse_gen_channel.sv
// One channel: input synchroniser, edge detector, IDLE/PULSE/HOLDOFF FSM with a
// shared length/holdoff down-counter, and a sticky missed-edge flag.
module pulse_gen_channel
    import pulse_gen_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 8,
    parameter int RETRIGGER   = 0
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 in_i,
    input  logic [1:0]           mode_i,
    input  logic [CNT_WIDTH-1:0] length_i,
    input  logic [CNT_WIDTH-1:0] holdoff_i,
    input  logic                 clr_missed_i,
    output logic                 out_o,
    output logic                 busy_o,
    output logic                 missed_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

    logic s;
    logic prev_q;
    logic edge_w;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk_in or negedge rst_n) begin
                if (!rst_n) sync_q <= '0;
                else        sync_q <= (sync_q << 1) | SYNC_STAGES'(in_i);
            end
            assign s = sync_q[SYNC_STAGES-1];
        end else begin : g_nosync
            assign s = in_i;
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= s;
    end

    assign edge_w = edge_detect(s, prev_q, mode_i);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] hold_q, hold_d;
    logic [CNT_WIDTH-1:0] len_eff;
    logic                 missed_q, missed_d;
    logic                 out_q, busy_q;
    logic                 missed_set;

    // A zero length still produces a one-cycle pulse.
    assign len_eff = (length_i == CNT_ZERO) ? CNT_ONE : length_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        missed_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (edge_w) begin
                    state_d = PULSE;
                    cnt_d   = len_eff - CNT_ONE;
                    hold_d  = holdoff_i;
                end
            end
            PULSE: begin
                if (edge_w && (RETRIGGER != 0)) begin
                    cnt_d  = len_eff - CNT_ONE;
                    hold_d = holdoff_i;
                end else begin
                    missed_set = edge_w;
                    if (cnt_q == CNT_ZERO) begin
                        if (hold_q != CNT_ZERO) begin
                            state_d = HOLDOFF;
                            cnt_d   = hold_q - CNT_ONE;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            HOLDOFF: begin
                missed_set = edge_w;
                if (cnt_q == CNT_ZERO) state_d = IDLE;
                else                   cnt_d   = cnt_q - CNT_ONE;
            end
            default: state_d = IDLE;
        endcase
        missed_d = (missed_q & ~clr_missed_i) | missed_set;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hold_q   <= '0;
            missed_q <= 1'b0;
            out_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            missed_q <= missed_d;
            out_q    <= (state_d == PULSE);
            busy_q   <= (state_d != IDLE);
        end
    end

    assign out_o    = out_q;
    assign busy_o   = busy_q;
    assign missed_o = missed_q;

endmodule

// File: rtl/pulse_gen_multi.sv
// Top level: CHANNELS independent edge-to-pulse channels sharing mode,
// length, holdoff and missed-clear controls.
module pulse_gen_multi
    import pulse_gen_pkg::*;
#(
    parameter int CHANNELS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 8,
    parameter int RETRIGGER   = 0
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic [CHANNELS-1:0]  in,
    input  logic [1:0]           mode,
    input  logic [CNT_WIDTH-1:0] length,
    input  logic [CNT_WIDTH-1:0] holdoff,
    input  logic                 clr_missed,
    output logic [CHANNELS-1:0]  out,
    output logic [CHANNELS-1:0]  busy,
    output logic [CHANNELS-1:0]  missed
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pulse_gen_channel #(
            .SYNC_STAGES(SYNC_STAGES),
            .CNT_WIDTH  (CNT_WIDTH),
            .RETRIGGER  (RETRIGGER)
        ) u_ch (
            .clk_in      (clk_in),
            .rst_n       (rst_n),
            .in_i        (in[i]),
            .mode_i      (mode),
            .length_i    (length),
            .holdoff_i   (holdoff),
            .clr_missed_i(clr_missed),
            .out_o       (out[i]),
            .busy_o      (busy[i]),
            .missed_o    (missed[i])
        );
    end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Bench for pulse_gen_multi: two instances (no retrigger / retrigger) share stimulus;
// a time-window reference model queues expected outputs, a monitor compares them.
module tb_pulse_gen_multi;

    localparam int CH = 8;
    localparam int SS = 2;
    localparam int CW = 8;

    logic          clk_in = 1'b0;
    logic          rst_n  = 1'b0;
    logic [CH-1:0] in_v   = '0;
    logic [1:0]    mode   = 2'b00;
    logic [CW-1:0] length = '0;
    logic [CW-1:0] holdoff = '0;
    logic          clr_missed = 1'b0;
    logic [CH-1:0] out0, busy0, missed0, out1, busy1, missed1;

    always #5 clk_in = ~clk_in;

    pulse_gen_multi #(.CHANNELS(CH), .SYNC_STAGES(SS), .CNT_WIDTH(CW), .RETRIGGER(0)) dut0 (
        .clk_in(clk_in), .rst_n(rst_n), .in(in_v), .mode(mode), .length(length),
        .holdoff(holdoff), .clr_missed(clr_missed), .out(out0), .busy(busy0), .missed(missed0));

    pulse_gen_multi #(.CHANNELS(CH), .SYNC_STAGES(SS), .CNT_WIDTH(CW), .RETRIGGER(1)) dut1 (
        .clk_in(clk_in), .rst_n(rst_n), .in(in_v), .mode(mode), .length(length),
        .holdoff(holdoff), .clr_missed(clr_missed), .out(out1), .busy(busy1), .missed(missed1));

    typedef struct packed {
        logic [CH-1:0] o0, b0, m0, o1, b1, m1;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: each channel is described by the last cycle its output is
    // high and the last cycle it is busy; an edge is served when the channel is
    // free (or, with retrigger, still pulsing), otherwise it is recorded as missed.
    initial begin
        logic [CH-1:0] hist [0:SS];
        int            out_last [2][CH];
        int            busy_last[2][CH];
        logic [CH-1:0] m_missed [2];
        logic [CH-1:0] ev_o [2];
        logic [CH-1:0] ev_b [2];
        int            cyc;
        int            len_c;
        logic          s, p, e, setm;
        exp_t          x;
        cyc = 0;
        forever begin
            @(posedge clk_in or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k <= SS; k++) hist[k] = '0;
                for (int r = 0; r < 2; r++) begin
                    m_missed[r] = '0;
                    for (int i = 0; i < CH; i++) begin
                        out_last[r][i]  = -1;
                        busy_last[r][i] = -1;
                    end
                end
                exp_q.delete();
                exp_q.push_back('0);
            end else begin
                cyc++;
                for (int r = 0; r < 2; r++) begin
                    for (int i = 0; i < CH; i++) begin
                        s = hist[SS-1][i];
                        p = hist[SS][i];
                        case (mode)
                            2'b00:   e = s && !p;
                            2'b01:   e = !s && p;
                            2'b10:   e = (s != p);
                            default: e = 1'b0;
                        endcase
                        setm = 1'b0;
                        if (e) begin
                            if ((cyc - 1 > busy_last[r][i]) || (r == 1 && cyc - 1 <= out_last[r][i])) begin
                                len_c = (length == 0) ? 1 : int'(length);
                                out_last[r][i]  = cyc + len_c - 1;
                                busy_last[r][i] = out_last[r][i] + int'(holdoff);
                            end else begin
                                setm = 1'b1;
                            end
                        end
                        m_missed[r][i] = (m_missed[r][i] && !clr_missed) || setm;
                        ev_o[r][i] = (cyc <= out_last[r][i]);
                        ev_b[r][i] = (cyc <= busy_last[r][i]);
                    end
                end
                for (int k = SS; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = in_v;
                x.o0 = ev_o[0]; x.b0 = ev_b[0]; x.m0 = m_missed[0];
                x.o1 = ev_o[1]; x.b1 = ev_b[1]; x.m1 = m_missed[1];
                exp_q.push_back(x);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({out0, busy0, missed0} !== {e.o0, e.b0, e.m0}) begin
                    n_bad++;
                    $display("FAIL rt0 @%0t out/busy/missed=%h/%h/%h expected %h/%h/%h",
                             $time, out0, busy0, missed0, e.o0, e.b0, e.m0);
                end
                n_cmp++;
                if ({out1, busy1, missed1} !== {e.o1, e.b1, e.m1}) begin
                    n_bad++;
                    $display("FAIL rt1 @%0t out/busy/missed=%h/%h/%h expected %h/%h/%h",
                             $time, out1, busy1, missed1, e.o1, e.b1, e.m1);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic pulse_reset(input int hold_cycles);
        @(posedge clk_in);
        #2 rst_n = 1'b0;
        wait_cyc(hold_cycles);
        rst_n = 1'b1;
    endtask

    task automatic pulse_clr();
        clr_missed = 1'b1;
        wait_cyc(1);
        clr_missed = 1'b0;
    endtask

    initial begin
        wait_cyc(3);
        rst_n = 1'b1;

        // basic: zero length gives a one-cycle pulse
        wait_cyc(3);
        in_v[0] = 1'b1;
        wait_cyc(8);

        // length 5, holdoff 3, second edge lands in holdoff
        length = 8'd5; holdoff = 8'd3;
        in_v[1] = 1'b1; wait_cyc(3);
        in_v[1] = 1'b0; wait_cyc(3);
        in_v[1] = 1'b1; wait_cyc(15);
        pulse_clr();
        wait_cyc(3);

        // modes on a period-20 square wave
        length = 8'd3; holdoff = 8'd0;
        for (int m = 1; m < 4; m++) begin
            mode = m[1:0];
            for (int k = 0; k < 6; k++) begin
                in_v[2] = ~in_v[2];
                wait_cyc(10);
            end
        end
        mode = 2'b00;
        pulse_clr();

        // retrigger: rising edges two cycles apart, three times
        length = 8'd4; holdoff = 8'd0;
        for (int k = 0; k < 6; k++) begin
            in_v[3] = ~in_v[3];
            wait_cyc(1);
        end
        wait_cyc(15);

        // asynchronous reset in the middle of a long pulse, input held high
        length = 8'd10; holdoff = 8'd2;
        in_v[4] = 1'b1;
        wait_cyc(5);
        pulse_reset(2);
        wait_cyc(25);

        // clear and holdoff edge in the same cycle: set wins
        in_v = '0; wait_cyc(20);
        length = 8'd3; holdoff = 8'd4;
        in_v[5] = 1'b1; wait_cyc(1);
        in_v[5] = 1'b0; wait_cyc(3);
        in_v[5] = 1'b1; wait_cyc(2);
        pulse_clr();
        wait_cyc(15);

        // all channels at once
        in_v = '0; wait_cyc(20);
        pulse_clr();
        in_v = '1; wait_cyc(20);

        // full-scale length
        in_v = '0; holdoff = 8'd0; length = 8'd255; wait_cyc(10);
        in_v[6] = 1'b1; wait_cyc(270);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            logic [CH-1:0] flip;
            for (int i = 0; i < CH; i++) flip[i] = ($urandom_range(0, 3) == 0);
            in_v = in_v ^ flip;
            if ($urandom_range(0, 49) == 0) begin
                mode    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                length  = 8'($urandom_range(0, 6));
                holdoff = 8'($urandom_range(0, 4));
            end
            clr_missed = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 399) == 0) pulse_reset(1);
            else wait_cyc(1);
        end
        clr_missed = 1'b0;
        wait_cyc(5);

        n_cmp++;
        if (exp_q.size() > 1) begin
            n_bad++;
            $display("FAIL queue_depth actual %0d required <=1", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_gen_multi.md
# pulse_gen_multi

Multi-channel, parametrised edge-to-pulse generator: each channel detects a selectable edge (rising, falling or both) on an asynchronous input and emits a programmable-length, single-clock-domain pulse. Optional hold-off dead time and sticky missed-edge flags are provided per channel. It sits between raw trigger/discriminator inputs and downstream counters/TDC/readout logic, replacing single-bit, single-cycle rising-edge pulse generators.

## Interface
- CHANNELS, 8: number of independent channels (≥1)
- SYNC_STAGES, 2: input synchroniser depth (0 = input already synchronous to clk_in)
- CNT_WIDTH, 8: width of length/holdoff counters
- RETRIGGER, 0: 0 = edges during PULSE ignored and flagged missed; 1 = edge during PULSE restarts length count
- clk_in  input  1  single clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in  input  CHANNELS  raw inputs, one per channel
- mode  input  2  edge select, shared: 00 rising, 01 falling, 10 both, 11 disabled
- length  input  CNT_WIDTH  pulse length in cycles; 0 treated as 1
- holdoff  input  CNT_WIDTH  dead time in cycles after pulse end; 0 = none
- clr_missed  input  1  synchronous clear of all missed flags
- out  output  CHANNELS  registered pulse outputs
- busy  output  CHANNELS  high while channel not IDLE
- missed  output  CHANNELS  sticky: an edge was detected but not served

## Operation
- Reset (rst_n low, async): out, busy, missed = 0; sync chain and previous-sample register = 0; all channels IDLE.
- Per channel: sync chain of SYNC_STAGES flops, then previous-sample flop; edge = function of (s, prev, mode). With prev reset to 0, an input held high across reset release yields one rising edge (mode 00/10).
- FSM states IDLE, PULSE, HOLDOFF.
- IDLE: on edge -> PULSE, latch len_q = max(length,1), hold_q = holdoff, counter = len_q-1, out = 1.
- PULSE: out = 1; counter decrements each cycle; at 0 -> HOLDOFF if hold_q≠0, else IDLE; out = 0 next cycle. Edge while PULSE: RETRIGGER=1 reloads counter to len_q-1 (current length/holdoff re-latched); RETRIGGER=0 sets missed.
- Edge on the final PULSE cycle with RETRIGGER=0 and hold_q=0: missed set; no back-to-back pulse.
- HOLDOFF: out = 0 for hold_q cycles, then IDLE; any edge sets missed.
- length/holdoff changes affect only pulses started afterwards. mode changes take effect next cycle for detection; in-flight pulses/holdoffs always complete; mode 11 blocks new pulses without setting missed.
- missed[i]: set on unserved edge, cleared by clr_missed; set wins when both in same cycle.
- Counters are CNT_WIDTH unsigned; no wrap (length = 2^CNT_WIDTH-1 gives exactly that many cycles).

## Timing
- E0 = first clk_in edge at which in is sampled in its new level by first stage (or by edge detector if SYNC_STAGES=0).
- out rises after edge E0+SYNC_STAGES; stays high exactly max(length,1) cycles.
- Minimum period between served pulses with RETRIGGER=0: max(length,1)+holdoff+1 cycles.
- busy rises with out, falls in the same cycle the channel re-enters IDLE.
- Input pulses shorter than one clock period may be lost (no capture on level change between edges); not flagged.
- Channels fully independent; simultaneous edges on all channels all served in the same cycle.

## Structure
- Package pulse_gen_pkg: state enum (IDLE, PULSE, HOLDOFF), mode constants (MODE_RISE, MODE_FALL, MODE_BOTH, MODE_OFF).
- Sub-module pulse_gen_channel (sync chain, edge detect, FSM, counter, missed flag); top generates CHANNELS instances and fans out shared controls.

## Test plan
- Reset/basic: SYNC_STAGES=2, mode 00, length 0, in[0] 0->1 at E0 -> out[0] high one cycle after E0+2, missed 0, other channels 0.
- Length/holdoff: length 5, holdoff 3, rising edges on in[1] 6 cycles apart -> first pulse 5 cycles, second edge in HOLDOFF ignored, missed[1]=1; clr_missed -> 0.
- Modes: square wave period 20 on in[2]; mode 01 -> pulses on falling only; mode 10 -> pulse on both; mode 11 -> no pulses, missed stays 0.
- Retrigger: RETRIGGER=1, length 4, edges 2 cycles apart x3 -> single out high 2+2+4=8 cycles, missed 0; RETRIGGER=0 same stimulus -> 4-cycle pulse, missed=1.
- Reset mid-pulse: length 10, assert rst_n low at cycle 3 of pulse -> out/busy 0 immediately (async); in held high through release -> exactly one pulse after release.
- Collision: clr_missed and a holdoff edge same cycle -> missed=1; all 8 channels edge simultaneously -> 8 identical pulses.
